policy_lookup_arbiter: RTL and testbench

Shares the single firewall lookup port of the policy server among `N_REQ` requesters (IP firewall instances), one lookup in flight at a time. Grants round-robin and issues the go pulse with the request word. Returns the server's permission word to the granted requester only, with a timeout on a lost response. Sits between the firewall wrappers and the policy server's `WSO_FW`/`UpdateWR_FW`/`WSI_FW`/`CaptureWR_FW` port, and holds off lookups while a policy write (`wr_FW`) is active.

---
 rtl/policy_lookup_arbiter_pkg.sv | 15 +
 rtl/policy_lookup_arbiter_if.sv | 30 +++
 rtl/policy_lookup_arbiter_rr_pick.sv | 28 ++
 rtl/policy_lookup_arbiter.sv | 114 +++++++++++
 tb/tb_policy_lookup_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/policy_lookup_arbiter_pkg.sv
// Shared types and default parameters for the policy lookup arbiter.
package policy_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/policy_lookup_arbiter_if.sv
// Requester-side and policy-server-side signals of the lookup arbiter.
interface policy_lookup_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_timeout;
  logic                    wr_FW;
  logic [DATA_W-1:0]       srv_wso;
  logic                    srv_update;
  logic [DATA_W-1:0]       srv_wsi;
  logic                    srv_capture;

  // master: requesters plus policy server; slave: the arbiter
  modport master (
    output req_valid, req_data, wr_FW, srv_wsi, srv_capture,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, srv_wso, srv_update
  );

  modport slave (
    input  req_valid, req_data, wr_FW, srv_wsi, srv_capture,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, srv_wso, srv_update
  );

endinterface

// File: rtl/policy_lookup_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request after the last grant.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic             o_any,
  output logic [IW-1:0]    o_idx
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int k);
    int s;
    s = k + int'(a);
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  // Scan from farthest to nearest so the nearest asserted index wins.
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req[wrap_add(i_last, k)]) o_idx = wrap_add(i_last, k);
    end
  end

endmodule

// File: rtl/policy_lookup_arbiter.sv
// Shares the policy server lookup port among N_REQ firewall requesters,
// one lookup in flight, round-robin grants, response timeout.
module policy_lookup_arbiter
  import policy_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  policy_lookup_arbiter_if.slave  bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_WAIT  = ST_WAIT;
  localparam logic [1:0] S_RESP  = ST_RESP;

  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [IW-1:0]     r_grant;
  logic [IW-1:0]     r_last;
  logic [TW-1:0]     r_timer;
  logic [N_REQ-1:0]  r_req_ready;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_timeout;
  logic [DATA_W-1:0] r_srv_wso;
  logic              r_srv_update;

  logic              w_any;
  logic [IW-1:0]     w_idx;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last),
    .o_any  (w_any),
    .o_idx  (w_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_last        <= IW'(N_REQ - 1);
      r_timer       <= '0;
      r_req_ready   <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
      r_srv_wso     <= '0;
      r_srv_update  <= 1'b0;
    end else begin
      r_req_ready  <= '0;
      r_srv_update <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!bus.wr_FW && w_any) begin
            r_grant      <= w_idx;
            r_last       <= w_idx;
            r_srv_wso    <= bus.req_data[w_idx*DATA_W +: DATA_W];
            r_req_ready  <= ONE << w_idx;
            r_srv_update <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          // A go pulse that overlapped a policy write is discarded and re-issued.
          if (r_srv_update && !bus.wr_FW) r_state <= S_WAIT;
          else r_srv_update <= !bus.wr_FW;
        end
        S_WAIT: begin
          if (bus.srv_capture) begin
            r_rsp_valid   <= ONE << r_grant;
            r_rsp_data    <= bus.srv_wsi;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_RESP;
          end else if (bus.wr_FW) begin
            r_timer <= '0;
            r_state <= S_ISSUE;
          end else if (r_timer == TW'(TIMEOUT)) begin
            r_rsp_valid   <= ONE << r_grant;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          r_rsp_valid   <= '0;
          r_rsp_data    <= '0;
          r_rsp_timeout <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.srv_wso     = r_srv_wso;
  assign bus.srv_update  = r_srv_update;

endmodule

// File: tb/tb_policy_lookup_arbiter.sv
// Directed self-checking bench for policy_lookup_arbiter (N_REQ=4, DATA_W=32, TIMEOUT=15).
module tb_policy_lookup_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  policy_lookup_arbiter_if #(.N_REQ(4), .DATA_W(32)) bus ();

  policy_lookup_arbiter #(.N_REQ(4), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] words [4];

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // From the ISSUE cycle: capture next cycle, check the response, return to IDLE.
  task automatic finish_lookup(input int idx, input logic [31:0] wsi, input string tag);
    step();
    bus.srv_capture = 1'b1;
    bus.srv_wsi     = wsi;
    step();
    bus.srv_capture = 1'b0;
    check({tag, "_rsp_valid"}, bus.rsp_valid, oh(idx));
    check({tag, "_rsp_data"}, bus.rsp_data, wsi);
    check({tag, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
    step();
  endtask

  // From an IDLE cycle with requests already driven.
  task automatic lookup(input int idx, input logic [31:0] wsi, input bit drop, input string tag);
    int n;
    n = 0;
    step();
    while (bus.req_ready == 4'b0 && n < 8) begin
      step();
      n++;
    end
    check({tag, "_ready"}, bus.req_ready, oh(idx));
    check({tag, "_update"}, bus.srv_update, 1'b1);
    check({tag, "_wso"}, bus.srv_wso, words[idx]);
    if (drop) bus.req_valid = 4'b0;
    finish_lookup(idx, wsi, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int early;
    words[0] = 32'h0002_0004;
    words[1] = 32'h1111_0001;
    words[2] = 32'h2222_0002;
    words[3] = 32'h3333_0003;
    rst             = 1'b1;
    bus.req_valid   = 4'b0;
    bus.req_data    = {words[3], words[2], words[1], words[0]};
    bus.wr_FW       = 1'b0;
    bus.srv_wsi     = 32'h0;
    bus.srv_capture = 1'b0;
    step();
    step();
    check("rst_req_ready", bus.req_ready, 4'b0);
    check("rst_rsp_valid", bus.rsp_valid, 4'b0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
    check("rst_srv_wso", bus.srv_wso, 32'h0);
    check("rst_srv_update", bus.srv_update, 1'b0);
    rst = 1'b0;
    step();

    // basic lookup, capture two cycles after the go pulse
    bus.req_valid = 4'b0001;
    step();
    check("t1_ready", bus.req_ready, 4'b0001);
    check("t1_update", bus.srv_update, 1'b1);
    check("t1_wso", bus.srv_wso, 32'h0002_0004);
    bus.req_valid = 4'b0;
    step();
    check("t1_update_one_cycle", bus.srv_update, 1'b0);
    step();
    bus.srv_capture = 1'b1;
    bus.srv_wsi     = 32'hA5A5_0001;
    step();
    bus.srv_capture = 1'b0;
    check("t1_rsp_valid", bus.rsp_valid, 4'b0001);
    check("t1_rsp_data", bus.rsp_data, 32'hA5A5_0001);
    check("t1_rsp_timeout", bus.rsp_timeout, 1'b0);
    step();
    check("t1_rsp_clear", bus.rsp_valid, 4'b0);
    check("t1_data_clear", bus.rsp_data, 32'h0);

    // round robin over 8 lookups, starting from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      lookup(i % 4, 32'hC0DE_0000 + 32'(i), 1'b0, $sformatf("rr%0d", i));
    end
    bus.req_valid = 4'b0;
    step();

    // policy write holds off arbitration
    bus.wr_FW     = 1'b1;
    bus.req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("wr_hold_ready%0d", i), bus.req_ready, 4'b0);
      check($sformatf("wr_hold_update%0d", i), bus.srv_update, 1'b0);
    end
    bus.wr_FW = 1'b0;
    lookup(1, 32'h0BAD_F00D, 1'b1, "wr_hold");

    // policy write during WAIT replays the go pulse
    bus.req_valid = 4'b0100;
    step();
    check("replay_ready", bus.req_ready, 4'b0100);
    check("replay_update1", bus.srv_update, 1'b1);
    bus.req_valid = 4'b0;
    step();
    bus.wr_FW = 1'b1;
    step();
    bus.wr_FW = 1'b0;
    check("replay_hold_update", bus.srv_update, 1'b0);
    check("replay_no_rsp", bus.rsp_valid, 4'b0);
    step();
    check("replay_update2", bus.srv_update, 1'b1);
    check("replay_wso", bus.srv_wso, words[2]);
    check("replay_no_ready", bus.req_ready, 4'b0);
    finish_lookup(2, 32'h5A5A_7777, "replay");
    check("replay_single_rsp", bus.rsp_valid, 4'b0);

    // lost response times out TIMEOUT+1 cycles after the first WAIT cycle
    bus.req_valid = 4'b1000;
    step();
    check("to_ready", bus.req_ready, 4'b1000);
    bus.req_valid = 4'b0;
    step();
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (bus.rsp_valid != 4'b0) early++;
    end
    check("to_no_early_rsp", 64'(early), 64'd0);
    step();
    check("to_rsp_valid", bus.rsp_valid, 4'b1000);
    check("to_rsp_timeout", bus.rsp_timeout, 1'b1);
    check("to_rsp_data", bus.rsp_data, 32'h0);
    step();
    bus.req_valid = 4'b0011;
    lookup(0, 32'h1234_5678, 1'b1, "after_to");

    // reset in the middle of WAIT
    bus.req_valid = 4'b0100;
    step();
    check("rstw_ready", bus.req_ready, 4'b0100);
    bus.req_valid = 4'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_wso", bus.srv_wso, 32'h0);
    check("rstw_update", bus.srv_update, 1'b0);
    check("rstw_rsp_valid", bus.rsp_valid, 4'b0);
    check("rstw_ready0", bus.req_ready, 4'b0);
    early = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.rsp_valid != 4'b0) early++;
    end
    check("rstw_no_rsp", 64'(early), 64'd0);
    bus.req_valid = 4'b1111;
    lookup(0, 32'hFEED_0000, 1'b1, "rstw_first");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
